stream_demux: RTL

Parametrised, registered 1-to-CHANNELS stream demultiplexer with valid/ready handshaking on every port. It replaces the combinational four-way single-bit demux in the control path. Each input word is steered to the channel given by its select value, or broadcast to all channels. Each output channel holds one registered entry, so one stalled consumer does not block traffic to other channels.

---
 rtl/stream_demux.sv | 81 ++++++++
 1 files changed

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-CHANNELS valid/ready demultiplexer with broadcast,
// one holding register per channel, and sticky tracking of out-of-range selects.
module stream_demux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      sel_err,
  output logic [7:0]                drop_cnt
);

  localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(CHANNELS);

  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] sel_hit;
  logic [CHANNELS-1:0] load;
  logic                in_range;
  logic                accept;
  logic                drop;

  // A channel can take a word when empty or when its entry leaves this same edge.
  assign free     = ~out_valid | out_ready;
  assign in_range = ({1'b0, in_sel} < SEL_LIMIT);

  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_hit[k] = (in_sel == SEL_W'(k));
    end
  end

  // Out-of-range words are always taken so a bad select cannot wedge the producer.
  always_comb begin
    if (in_bcast) begin
      in_ready = &free;
    end else if (!in_range) begin
      in_ready = 1'b1;
    end else begin
      in_ready = |(free & sel_hit);
    end
  end

  assign accept = in_valid & in_ready;
  assign load   = accept ? (in_bcast ? {CHANNELS{1'b1}} : sel_hit) : '0;
  assign drop   = accept & ~in_bcast & ~in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      sel_err   <= 1'b0;
      drop_cnt  <= 8'd0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (load[k]) begin
          out_valid[k]                 <= 1'b1;
          out_data[k*WIDTH +: WIDTH]   <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k]                 <= 1'b0;
        end
      end
      if (drop) begin
        sel_err <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule
